fletcher32_checker: RTL and testbench
=====================================

// Module: fletcher32_checker
// PURPOSE
//  Receive side of the Fletcher-32 stream: consumes a length-prefixed frame of
//  16-bit words with a trailing checksum, recomputes Fletcher-32 on the fly and
//  returns one 33-bit verdict per frame. Pairs with the Fletcher-32 generator
//  unit; sits between the latency-insensitive source and the result sink.
// PARAMETERS
//  LEN_NBITS   16      width of the length word and internal word counter
//  INIT_SUM    16'h0   reset/start value of both running sums sum1, sum2
// PORTS
//  clk        in   1   clock
//  reset      in   1   asynchronous, active-high reset
//  recv_val   in   1   input word valid
//  recv_rdy   out  1   block ready to accept an input word
//  recv_msg   in   16  input word (length, data, or checksum half)
//  send_val   out  1   verdict valid
//  send_rdy   in   1   sink ready for verdict
//  send_msg   out  33  [32]=pass, [31:0]={sum2,sum1} computed checksum
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high (clk, reset).
//  Transfer occurs on a cycle where val && rdy on that port; no other cycle.
//  Frame format: N (count), data[0..N-1], CK_HI (expected sum2), CK_LO (sum1).
//  States: IDLE -> DATA -> CK_HI -> CK_LO -> RESP -> IDLE.
//   IDLE : recv_rdy=1; on transfer cnt<=recv_msg, sums<=INIT_SUM;
//          go DATA if recv_msg!=0, else go CK_HI directly (N=0 frame).
//   DATA : recv_rdy=1; per transfer update sums, cnt<=cnt-1; go CK_HI when
//          the transfer consumes the last word (cnt==1).
//   CK_HI: recv_rdy=1; on transfer latch exp_hi, go CK_LO.
//   CK_LO: recv_rdy=1; on transfer compute pass, register send_msg, go RESP.
//   RESP : recv_rdy=0, send_val=1; send_msg held stable until send_rdy;
//          on send transfer go IDLE (next word accepted following cycle).
//  Arithmetic (per data word w, one word per cycle, no stalls):
//   sum1' = (sum1 + w) mod 65535; sum2' = (sum2 + sum1') mod 65535.
//   mod: 17-bit add, subtract 16'hFFFF if result >= 16'hFFFF; sums in 0..FFFE.
//  Compare: each received half normalised (16'hFFFF -> 16'h0000) then
//   pass = (norm(CK_HI)==sum2) && (norm(CK_LO)==sum1).
//  Latency: verdict valid the cycle after the CK_LO transfer.
//  Throughput: N+3 input cycles + 1 response cycle per frame, min.
//  Reset (any state, mid-frame included): state<=IDLE, cnt<=0,
//   sums<=INIT_SUM, send_val=0, send_msg=0, recv_rdy=0 while reset high;
//   partial frame discarded, no verdict emitted for it.
//  recv_val low mid-frame: state/sums hold, no timeout.
//  send_rdy low in RESP: recv_rdy stays 0 (no input buffering).
//  N up to 2^LEN_NBITS-1 words; counter never wraps within a frame.
//  recv_msg ignored when no transfer; X on recv_msg without recv_val is benign.
// TESTING
//  N=3, data 6261,6463,6665, ck 5650,2D2A -> send_msg = {1'b1,32'h56502D2A}.
//  Same data, ck 5650,2D2B -> {1'b0,32'h56502D2A}; next frame unaffected.
//  N=0, ck 0000,0000 -> {1,0}; N=0, ck FFFF,FFFF -> {1,0} (normalisation).
//  N=2, data FFFF,FFFF, ck 0000,0000 -> {1,0} (mod-65535 wrap path).
//  "abcdef" frame with recv_val gaps and send_rdy low 5 cycles -> recv_rdy=0
//   and send_msg stable during stall; verdict accepted, IDLE next cycle.
//  Reset asserted after 2 of 3 data words -> no verdict; then full "abcdef"
//   frame -> {1,32'h56502D2A}; back-to-back frames checked by src/sink pair.

Source files
------------

// File: rtl/fletcher32_checker.sv
// Receive-side Fletcher-32 checker: consumes N, N data words and a two-word
// checksum, then presents a 33-bit verdict {pass, sum2, sum1} until accepted.
module fletcher32_checker #(
  parameter int          LEN_NBITS = 16,
  parameter logic [15:0] INIT_SUM  = 16'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        recv_val,
  output logic        recv_rdy,
  input  logic [15:0] recv_msg,
  output logic        send_val,
  input  logic        send_rdy,
  output logic [32:0] send_msg
);

  typedef enum logic [2:0] {IDLE, DATA, CK_HI, CK_LO, RESP} state_t;

  state_t                 state_q, state_d;
  logic [LEN_NBITS-1:0]   cnt_q, cnt_d;
  logic [15:0]            sum1_q, sum1_d;
  logic [15:0]            sum2_q, sum2_d;
  logic [15:0]            exp_hi_q, exp_hi_d;
  logic [32:0]            send_msg_q, send_msg_d;

  logic        recv_fire;
  logic        send_fire;
  logic [15:0] sum1_nxt;
  logic [15:0] sum2_nxt;
  logic        pass;

  // One's-complement style modulo-65535 add; result always in 0..FFFE.
  function automatic logic [15:0] mod_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 17'h0FFFF) s = s - 17'h0FFFF;
    return s[15:0];
  endfunction

  function automatic logic [15:0] norm(input logic [15:0] x);
    return (x == 16'hFFFF) ? 16'h0000 : x;
  endfunction

  assign recv_rdy  = !reset && (state_q != RESP);
  assign send_val  = (state_q == RESP);
  assign send_msg  = send_msg_q;
  assign recv_fire = recv_val && recv_rdy;
  assign send_fire = send_val && send_rdy;

  assign sum1_nxt = mod_add(sum1_q, recv_msg);
  assign sum2_nxt = mod_add(sum2_q, sum1_nxt);
  assign pass     = (norm(exp_hi_q) == sum2_q) && (norm(recv_msg) == sum1_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum1_d     = sum1_q;
    sum2_d     = sum2_q;
    exp_hi_d   = exp_hi_q;
    send_msg_d = send_msg_q;
    case (state_q)
      IDLE: if (recv_fire) begin
        cnt_d   = LEN_NBITS'(recv_msg);
        sum1_d  = INIT_SUM;
        sum2_d  = INIT_SUM;
        state_d = (recv_msg != 16'h0) ? DATA : CK_HI;
      end
      DATA: if (recv_fire) begin
        sum1_d = sum1_nxt;
        sum2_d = sum2_nxt;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == LEN_NBITS'(1)) state_d = CK_HI;
      end
      CK_HI: if (recv_fire) begin
        exp_hi_d = recv_msg;
        state_d  = CK_LO;
      end
      CK_LO: if (recv_fire) begin
        send_msg_d = {pass, sum2_q, sum1_q};
        state_d    = RESP;
      end
      RESP: if (send_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sum1_q     <= INIT_SUM;
      sum2_q     <= INIT_SUM;
      exp_hi_q   <= 16'h0;
      send_msg_q <= 33'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum1_q     <= sum1_d;
      sum2_q     <= sum2_d;
      exp_hi_q   <= exp_hi_d;
      send_msg_q <= send_msg_d;
    end
  end

endmodule

// File: tb/tb_fletcher32_checker.sv
// Directed bench for fletcher32_checker using hand-computed checksum vectors.
module tb_fletcher32_checker;

  logic        clk;
  logic        reset;
  logic        recv_val;
  logic        recv_rdy;
  logic [15:0] recv_msg;
  logic        send_val;
  logic        send_rdy;
  logic [32:0] send_msg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] dat [8];

  fletcher32_checker #(.LEN_NBITS(16), .INIT_SUM(16'h0)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic put_word(input logic [15:0] w, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    recv_val = 1'b1;
    recv_msg = w;
    n = 0;
    while (!recv_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("recv_rdy_timeout", 33'(recv_rdy), 33'h1);
    @(posedge clk);
    #1;
    recv_val = 1'b0;
    recv_msg = 16'hDEAD;
  endtask

  task automatic put_frame(input int n, input logic [15:0] hi, input logic [15:0] lo, input int gap);
    put_word(16'(n), gap);
    for (int i = 0; i < n; i++) put_word(dat[i], gap);
    put_word(hi, gap);
    put_word(lo, gap);
  endtask

  task automatic get_verdict(input string tag, input logic [32:0] exp, input int stall);
    int n;
    logic [32:0] first;
    @(negedge clk);
    check({tag, "_lat"}, 33'(send_val), 33'h1);
    n = 0;
    while (!send_val && n < 50) begin
      @(negedge clk);
      n++;
    end
    first = send_msg;
    check(tag, send_msg, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_rdy"}, 33'(recv_rdy), 33'h0);
      check({tag, "_stall_msg"}, send_msg, first);
    end
    send_rdy = 1'b1;
    @(posedge clk);
    #1;
    send_rdy = 1'b0;
    @(negedge clk);
    check({tag, "_idle_val"}, 33'(send_val), 33'h0);
    check({tag, "_idle_rdy"}, 33'(recv_rdy), 33'h1);
  endtask

  initial begin
    reset    = 1'b1;
    recv_val = 1'b0;
    recv_msg = 16'h0;
    send_rdy = 1'b0;
    dat[0] = 16'h6261; dat[1] = 16'h6463; dat[2] = 16'h6665;
    repeat (3) @(negedge clk);
    check("rst_recv_rdy", 33'(recv_rdy), 33'h0);
    check("rst_send_val", 33'(send_val), 33'h0);
    check("rst_send_msg", send_msg, 33'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 33'(recv_rdy), 33'h1);

    put_frame(3, 16'h5650, 16'h2D2A, 0);
    get_verdict("abcdef_ok", {1'b1, 32'h56502D2A}, 0);
    put_frame(3, 16'h5650, 16'h2D2B, 0);
    get_verdict("abcdef_badlo", {1'b0, 32'h56502D2A}, 0);
    put_frame(3, 16'h5650, 16'h2D2A, 0);
    get_verdict("abcdef_after_bad", {1'b1, 32'h56502D2A}, 0);
    put_frame(3, 16'hFFFF, 16'hFFFF, 0);
    get_verdict("abcdef_badboth", {1'b0, 32'h56502D2A}, 0);

    put_frame(0, 16'h0000, 16'h0000, 0);
    get_verdict("n0_zero", {1'b1, 32'h0}, 0);
    put_frame(0, 16'hFFFF, 16'hFFFF, 0);
    get_verdict("n0_ffff", {1'b1, 32'h0}, 0);

    dat[0] = 16'hFFFF; dat[1] = 16'hFFFF;
    put_frame(2, 16'h0000, 16'h0000, 0);
    get_verdict("wrap_ffff", {1'b1, 32'h0}, 0);
    dat[0] = 16'hFFFE;
    put_frame(1, 16'hFFFE, 16'hFFFE, 0);
    get_verdict("max_fffe", {1'b1, 32'hFFFEFFFE}, 0);
    dat[0] = 16'h0001;
    put_frame(1, 16'h0001, 16'h0001, 0);
    get_verdict("one_word", {1'b1, 32'h00010001}, 0);

    dat[0] = 16'h6261; dat[1] = 16'h6463; dat[2] = 16'h6665;
    put_frame(3, 16'h5650, 16'h2D2A, 2);
    get_verdict("gaps_stall", {1'b1, 32'h56502D2A}, 5);

    put_word(16'd3, 0);
    put_word(dat[0], 0);
    put_word(dat[1], 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rdy", 33'(recv_rdy), 33'h0);
    check("midrst_val", 33'(send_val), 33'h0);
    check("midrst_msg", send_msg, 33'h0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_noverdict", 33'(send_val), 33'h0);
    put_frame(3, 16'h5650, 16'h2D2A, 0);
    get_verdict("after_rst", {1'b1, 32'h56502D2A}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
